// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART TX core among N_REQ byte sources.
// Tracks the core busy handshake per frame, adds a lock-based enable and a sticky watchdog error.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned DATAWIDTH_BUS  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned STATE_SIZE     = 3
) (
   input  logic                           UART_ARB_CLOCK_50,
   input  logic                           UART_ARB_RESET_InLow,
   input  logic                           UART_ARB_enable_InHigh,
   input  logic [N_REQ-1:0]               UART_ARB_req_InHigh,
   input  logic [N_REQ*DATAWIDTH_BUS-1:0] UART_ARB_data_In,
   output logic [N_REQ-1:0]               UART_ARB_ack_Out,
   output logic [$clog2(N_REQ)-1:0]       UART_ARB_grant_Out,
   output logic                           UART_ARB_active_Out,
   output logic                           UART_ARB_error_Out,
   output logic                           UART_ARB_txLock_Out,
   output logic                           UART_ARB_txNewData_Out,
   output logic [DATAWIDTH_BUS-1:0]       UART_ARB_txData_Out,
   input  logic                           UART_ARB_txBusy_In
);

   localparam int unsigned GW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [STATE_SIZE-1:0] {
      S_SYNC, S_IDLE, S_LOCKED, S_ISSUE,
      S_WAIT_START, S_WAIT_STOP, S_WAIT_REARM, S_WAIT_READY
   } state_t;

   state_t                   state, state_d;
   logic                     seen, seen_d;
   logic [CW-1:0]            wd_cnt, wd_cnt_d;
   logic [GW-1:0]            rr_ptr, rr_ptr_d;
   logic [N_REQ-1:0]         ack_d;
   logic [GW-1:0]            grant_d;
   logic                     active_d, error_d, tx_lock_d, tx_new_data_d;
   logic [DATAWIDTH_BUS-1:0] tx_data_d;
   logic                     timed;
   logic                     win_found;
   logic [GW-1:0]            win_idx;
   logic [GW-1:0]            scan_idx;
   logic                     busy;

   assign busy = UART_ARB_txBusy_In;

   // First asserted request at or after the round-robin pointer, wrapping at N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         scan_idx = GW'((32'(rr_ptr) + k) % N_REQ);
         if (!win_found && UART_ARB_req_InHigh[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d       = state;
      seen_d        = 1'b0;
      wd_cnt_d      = '0;
      rr_ptr_d      = rr_ptr;
      ack_d         = '0;
      grant_d       = UART_ARB_grant_Out;
      active_d      = UART_ARB_active_Out;
      error_d       = UART_ARB_error_Out;
      tx_lock_d     = 1'b0;
      tx_new_data_d = 1'b0;
      tx_data_d     = UART_ARB_txData_Out;
      timed         = 1'b0;

      case (state)
         S_SYNC: begin
            if (seen && !busy) begin
               state_d = S_IDLE;
            end else begin
               seen_d = seen | busy;
               timed  = 1'b1;
            end
         end
         S_IDLE: begin
            if (!UART_ARB_enable_InHigh) begin
               state_d   = S_LOCKED;
               tx_lock_d = 1'b1;
            end else if (win_found) begin
               state_d       = S_ISSUE;
               ack_d         = N_REQ'(1) << win_idx;
               grant_d       = win_idx;
               rr_ptr_d      = GW'((32'(win_idx) + 32'd1) % N_REQ);
               tx_data_d     = DATAWIDTH_BUS'(UART_ARB_data_In >> (32'(win_idx) * DATAWIDTH_BUS));
               tx_new_data_d = 1'b1;
               active_d      = 1'b1;
            end
         end
         S_LOCKED: begin
            if (UART_ARB_enable_InHigh) state_d = S_SYNC;
            else                        tx_lock_d = 1'b1;
         end
         S_ISSUE: state_d = S_WAIT_START;
         S_WAIT_START: begin
            if (busy) state_d = S_WAIT_STOP;
            else      timed   = 1'b1;
         end
         S_WAIT_STOP: begin
            if (!busy) state_d = S_WAIT_REARM;
         end
         S_WAIT_REARM: begin
            if (busy) state_d = S_WAIT_READY;
            else      timed   = 1'b1;
         end
         S_WAIT_READY: begin
            if (!busy) begin
               state_d  = S_IDLE;
               active_d = 1'b0;
            end else begin
               timed = 1'b1;
            end
         end
         default: state_d = S_SYNC;
      endcase

      // Watchdog: the in-flight byte is dropped and the core is re-synchronised.
      if (timed) begin
         if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            error_d  = 1'b1;
            active_d = 1'b0;
            state_d  = S_SYNC;
         end else begin
            wd_cnt_d = wd_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge UART_ARB_CLOCK_50 or negedge UART_ARB_RESET_InLow) begin
      if (!UART_ARB_RESET_InLow) begin
         state                  <= S_SYNC;
         seen                   <= 1'b0;
         wd_cnt                 <= '0;
         rr_ptr                 <= '0;
         UART_ARB_ack_Out       <= '0;
         UART_ARB_grant_Out     <= '0;
         UART_ARB_active_Out    <= 1'b0;
         UART_ARB_error_Out     <= 1'b0;
         UART_ARB_txLock_Out    <= 1'b0;
         UART_ARB_txNewData_Out <= 1'b0;
         UART_ARB_txData_Out    <= '0;
      end else begin
         state                  <= state_d;
         seen                   <= seen_d;
         wd_cnt                 <= wd_cnt_d;
         rr_ptr                 <= rr_ptr_d;
         UART_ARB_ack_Out       <= ack_d;
         UART_ARB_grant_Out     <= grant_d;
         UART_ARB_active_Out    <= active_d;
         UART_ARB_error_Out     <= error_d;
         UART_ARB_txLock_Out    <= tx_lock_d;
         UART_ARB_txNewData_Out <= tx_new_data_d;
         UART_ARB_txData_Out    <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a UART TX core model feeds a serial decoder; grants and bytes
// are predicted from the round-robin rule and checked through a scoreboard queue.
module tb_uart_tx_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 8;
   localparam int unsigned TO  = 16;
   localparam int unsigned CPB = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N*DW-1:0] data = '0;
   logic [N-1:0]  ack;
   logic [1:0]    grant;
   logic          active, error, tx_lock, tx_new_data;
   logic [DW-1:0] tx_data;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .DATAWIDTH_BUS(DW), .TIMEOUT_CYCLES(TO), .STATE_SIZE(3)) dut (
      .UART_ARB_CLOCK_50      (clk),
      .UART_ARB_RESET_InLow   (rst_n),
      .UART_ARB_enable_InHigh (enable),
      .UART_ARB_req_InHigh    (req),
      .UART_ARB_data_In       (data),
      .UART_ARB_ack_Out       (ack),
      .UART_ARB_grant_Out     (grant),
      .UART_ARB_active_Out    (active),
      .UART_ARB_error_Out     (error),
      .UART_ARB_txLock_Out    (tx_lock),
      .UART_ARB_txNewData_Out (tx_new_data),
      .UART_ARB_txData_Out    (tx_data),
      .UART_ARB_txBusy_In     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // UART TX core model, CLOCK_PER_BIT = CPB.
   typedef enum int {C_BOOT, C_LOCK, C_READY, C_FRAME} core_t;
   core_t   cst;
   logic    line;
   int      bitn, cyc;
   logic [DW-1:0] shreg;
   logic    stuck = 1'b0;
   logic    kick  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cst <= C_BOOT; busy <= 1'b0; line <= 1'b1; bitn <= 0; cyc <= 0; shreg <= '0;
      end else begin
         case (cst)
            C_BOOT: begin busy <= 1'b1; cst <= C_LOCK; end
            C_LOCK: if (!tx_lock) begin busy <= 1'b0; cst <= C_READY; end
            C_READY: begin
               if (tx_lock || kick) begin
                  busy <= 1'b1; cst <= C_LOCK;
               end else if (tx_new_data && !stuck) begin
                  busy <= 1'b1; line <= 1'b0; shreg <= tx_data; bitn <= 0; cyc <= 0; cst <= C_FRAME;
               end
            end
            C_FRAME: begin
               if (cyc < int'(CPB) - 1) begin
                  cyc <= cyc + 1;
               end else begin
                  cyc <= 0;
                  if (bitn == 9) begin
                     busy <= 1'b1; line <= 1'b1; cst <= C_LOCK;
                  end else begin
                     bitn <= bitn + 1;
                     if (bitn < 8) line <= shreg[bitn[2:0]];
                     else begin line <= 1'b1; busy <= 1'b0; end
                  end
               end
            end
            default: cst <= C_BOOT;
         endcase
      end
   end

   // Reference model state and scoreboard.
   logic [DW-1:0] exp_q[$];
   int            grants[$];
   int            model_ptr = 0;
   logic          no_ack = 1'b0;
   logic [DW-1:0] cur_byte = '0;
   int            frames = 0;
   int            rst_epoch = 0;

   logic [N-1:0]    req_s;
   logic [N*DW-1:0] data_s;
   logic            en_s;
   always @(posedge clk) begin
      req_s  <= req;
      data_s <= data;
      en_s   <= enable;
   end

   always @(negedge rst_n) rst_epoch++;

   // Grant monitor: predicts the winner from the sampled requests and the model pointer.
   initial begin : monitor
      int w;
      int idx;
      logic [DW-1:0] b;
      forever begin
         @(negedge clk);
         if (rst_n && (ack != '0 || tx_new_data)) begin
            w = -1;
            for (int k = 0; k < int'(N); k++) begin
               idx = (model_ptr + k) % int'(N);
               if (w < 0 && ((req_s >> idx) & N'(1)) != '0) w = idx;
            end
            chk("newdata_with_ack", 32'(tx_new_data), 32'd1);
            chk("enable_at_grant", 32'(en_s), 32'd1);
            chk("grant_allowed_now", 32'(no_ack), 32'd0);
            chk("core_ready_at_grant", 32'(cst == C_READY), 32'd1);
            chk("lock_low_at_grant", 32'(tx_lock), 32'd0);
            if (w < 0) begin
               checks++; errors++;
               $display("FAIL ack_without_request: ack=0x%0h, expected no ack (req=0x%0h)", ack, req_s);
            end else begin
               b = DW'(data_s >> (w * int'(DW)));
               chk("ack_onehot", 32'(ack), 32'(N'(1) << w));
               chk("grant_index", 32'(grant), 32'(w));
               chk("tx_data_latched", 32'(tx_data), 32'(b));
               chk("active_on_issue", 32'(active), 32'd1);
               exp_q.push_back(b);
               grants.push_back(w);
               cur_byte  = b;
               model_ptr = (w + 1) % int'(N);
            end
         end else if (rst_n && active) begin
            chk("tx_data_hold", 32'(tx_data), 32'(cur_byte));
         end
      end
   end

   // Serial line decoder: samples mid-bit and checks against the scoreboard.
   initial begin : decoder
      logic [DW-1:0] b;
      logic stopb;
      int ep;
      forever begin
         @(negedge clk);
         if (rst_n && line === 1'b0) begin
            ep = rst_epoch;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = line;
            end
            repeat (CPB) @(negedge clk);
            stopb = line;
            if (ep == rst_epoch) begin
               chk("stop_bit", 32'(stopb), 32'd1);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", b);
               end else begin
                  chk("frame_byte", 32'(b), 32'(exp_q.pop_front()));
               end
               frames++;
            end
         end
      end
   end

   task automatic check_reset_outputs();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_txlock", 32'(tx_lock), 32'd0);
      chk("rst_txnewdata", 32'(tx_new_data), 32'd0);
      chk("rst_txdata", 32'(tx_data), 32'd0);
   endtask

   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      grants.delete();
      model_ptr = 0;
      cur_byte  = '0;
      repeat (hold) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_frames(input string name, input int n, input int budget);
      int start;
      int c;
      start = frames;
      c = 0;
      while (frames < start + n && c < budget) begin @(negedge clk); c++; end
      chk(name, 32'(frames - start >= n), 32'd1);
   endtask

   task automatic drain(input string name);
      int c;
      req = '0;
      c = 0;
      while ((exp_q.size() != 0 || active || cst != C_READY) && c < 400) begin @(negedge clk); c++; end
      chk(name, 32'(c < 400), 32'd1);
   endtask

   initial begin : global_timeout
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin : stimulus
      int n;
      int seen_grants[8];
      seen_grants = '{0, 1, 2, 3, 0, 1, 2, 3};

      // Reset values, then a single requester.
      repeat (3) @(negedge clk);
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      req  = 4'b0001;
      data = {8'h44, 8'h33, 8'h22, 8'hA5};
      wait_frames("first_frame", 1, 200);
      req = '0;
      n = 0;
      while (active && n < 20) begin @(negedge clk); n++; end
      chk("active_falls", 32'(active), 32'd0);
      chk("active_falls_core_ready", 32'(busy), 32'd0);
      drain("drain_first");

      // Full request vector for eight frames from a fresh pointer, then pointer wrap.
      @(negedge clk);
      do_reset(3);
      req  = 4'b1111;
      data = {8'h44, 8'h33, 8'h22, 8'h11};
      wait_frames("eight_frames", 8, 800);
      req = 4'b1001;
      wait_frames("wrap_frames", 2, 250);
      chk("grant_count", 32'(grants.size() >= 10), 32'd1);
      if (grants.size() >= 10) begin
         for (int i = 0; i < 8; i++) chk("rr_order", 32'(grants[i]), 32'(seen_grants[i]));
         chk("wrap_to_0", 32'(grants[8]), 32'd0);
         chk("wrap_then_3", 32'(grants[9]), 32'd3);
      end
      drain("drain_wrap");

      // Enable dropped mid-frame: the frame completes, then the core is held locked.
      req  = 4'b0100;
      data = {8'h0F, 8'hC3, 8'h5A, 8'h96};
      n = 0;
      while (cst != C_FRAME && n < 100) begin @(negedge clk); n++; end
      enable = 1'b0;
      n = 0;
      while (!tx_lock && n < 200) begin @(negedge clk); n++; end
      chk("lock_after_frame", 32'(tx_lock), 32'd1);
      chk("frame_done_before_lock", 32'(exp_q.size()), 32'd0);
      chk("inactive_when_locked", 32'(active), 32'd0);
      repeat (30) @(negedge clk);
      chk("lock_held", 32'(tx_lock), 32'd1);
      enable = 1'b1;
      wait_frames("served_after_unlock", 1, 200);
      chk("unlocked", 32'(tx_lock), 32'd0);
      drain("drain_enable");

      // Core stuck at busy=0: watchdog error, byte dropped, recovery after handshake.
      stuck = 1'b1;
      req = 4'b0010;
      n = 0;
      while (ack == '0 && n < 200) begin @(negedge clk); n++; end
      chk("stuck_ack_seen", 32'(ack != '0), 32'd1);
      req = '0;
      n = 0;
      while (!error && n < 100) begin @(negedge clk); n++; end
      chk("watchdog_latency", 32'(n), 32'(TO + 1));
      chk("active_cleared_on_error", 32'(active), 32'd0);
      exp_q.delete();
      no_ack = 1'b1;
      req = 4'b1111;
      repeat (60) @(negedge clk);
      chk("error_sticky", 32'(error), 32'd1);
      no_ack = 1'b0;
      stuck = 1'b0;
      kick = 1'b1;
      @(negedge clk);
      kick = 1'b0;
      wait_frames("recovered", 1, 200);
      chk("error_still_set", 32'(error), 32'd1);

      // Reset during data bits: immediate reset values, SYNC before the next grant.
      n = 0;
      while (!(cst == C_FRAME && bitn >= 2 && bitn <= 6) && n < 200) begin @(negedge clk); n++; end
      do_reset(40);
      n = 0;
      while (ack == '0 && n < 50) begin @(negedge clk); n++; end
      chk("sync_before_grant", 32'(n), 32'd4);
      chk("error_cleared_by_reset", 32'(error), 32'd0);
      drain("drain_reset");

      // Randomized requests, bytes and enable.
      for (int it = 0; it < 14; it++) begin
         req    = N'($urandom_range(0, 15));
         data   = {$urandom()};
         enable = ($urandom_range(0, 5) != 0);
         repeat ($urandom_range(60, 250)) @(negedge clk);
      end
      enable = 1'b1;
      drain("drain_random");
      chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter core among N_REQ byte requesters.
- Arbitrates, latches the winning byte, and drives the core's lock/newData/data inputs.
- Tracks core busy through every frame phase; adds a system enable (lock) and a watchdog error.
- Sits between the application byte sources and the UART_TX core. Both run on the same clock and share the same reset event; the core's active-high reset is the inverse of this block's reset.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATAWIDTH_BUS, 8, byte width; must match the TX core
- TIMEOUT_CYCLES, 16, maximum cycles in any short busy-handshake phase before an error is declared
- STATE_SIZE, 3, state register width

Ports:
- UART_ARB_CLOCK_50  in  1  system clock (50 MHz)
- UART_ARB_RESET_InLow  in  1  asynchronous reset, active low
- UART_ARB_enable_InHigh  in  1  1 = transmit allowed; 0 = hold the core locked once idle
- UART_ARB_req_InHigh  in  N_REQ  level request, one bit per requester
- UART_ARB_data_In  in  N_REQ*DATAWIDTH_BUS  packed bytes; requester i uses bits [8i+7:8i]
- UART_ARB_ack_Out  out  N_REQ  one-cycle pulse: the byte of requester i was latched
- UART_ARB_grant_Out  out  $clog2(N_REQ)  index of the last-granted requester
- UART_ARB_active_Out  out  1  a frame is in flight
- UART_ARB_error_Out  out  1  sticky watchdog error
- UART_ARB_txLock_Out  out  1  to the core LOCK input
- UART_ARB_txNewData_Out  out  1  to the core newData input
- UART_ARB_txData_Out  out  DATAWIDTH_BUS  to the core data input
- UART_ARB_txBusy_In  in  1  from the core busy output

Behaviour:
- All outputs are registered.
- Reset values: ack=0, grant=0, active=0, error=0, txLock=0, txNewData=0, txData=0, rr pointer=0, state=SYNC, timeout counter=0.
- Core busy contract, a decided fact:
  - busy=0 after reset for 1 cycle, then 1 while the core is locked.
  - busy=0 while ready (unlocked idle).
  - busy=1 during start and data bits.
  - busy=0 during the stop bit.
  - busy=1 for at least 1 cycle (locked idle) after the stop bit.
  - busy=0 again once the core is ready.
- States:
  - SYNC: txLock=0. Wait for busy=1 then busy=0, using an internal seen-high flag. Then go to IDLE.
  - IDLE:
    - enable=0: go to LOCKED with txLock=1.
    - else, any req set: pick the first set bit scanning from the rr pointer upward, wrapping at N_REQ. Latch that requester's byte into txData, pulse ack[i], set grant=i and pointer=(i+1) mod N_REQ. Go to ISSUE.
    - Enable takes priority over req in the same cycle.
  - LOCKED: txLock=1. When enable=1, go to SYNC with txLock=0.
  - ISSUE: txNewData=1 for exactly 1 cycle; active=1. Go to WAIT_START.
  - WAIT_START: wait for busy=1. Then go to WAIT_STOP.
  - WAIT_STOP: wait for busy=0 (stop bit). This phase is untimed. Then go to WAIT_REARM.
  - WAIT_REARM: wait for busy=1. Then go to WAIT_READY.
  - WAIT_READY: wait for busy=0. Then active=0, go to IDLE.
- Hold rules:
  - txData is held stable from ISSUE until IDLE is re-entered.
  - txLock=0 in every state except LOCKED.
- Watchdog:
  - The counter runs in SYNC, WAIT_START, WAIT_REARM and WAIT_READY, and clears on every state change.
  - When count reaches TIMEOUT_CYCLES: error=1 (sticky until reset), active=0, go to SYNC.
  - No ack is re-issued; the byte is dropped.
- Requests are level-sensitive. A requester still asserting req after its ack is treated as a new request, served on its next round-robin turn.
- Request or data changes outside the IDLE arbitration cycle have no effect.
- Mid-frame events:
  - enable dropped mid-frame: the frame completes, then LOCKED.
  - Reset mid-frame: all registers return to reset values immediately.
- Throughput: at most one byte per frame. No new grant is issued until WAIT_READY completes.

Test Plan:
- Reset release, core model with CLOCK_PER_BIT=4; req=4'b0001, byte0=0xA5 → after SYNC, ack[0] for 1 cycle, grant=0, txNewData single pulse with txData=0xA5. The core line shows start, 10100101 LSB first, stop. active falls when busy returns low after rearm.
- req=4'b1111 held for 8 frames, bytes 0x11/0x22/0x33/0x44 → grant order 0,1,2,3,0,1,2,3; exactly one ack per frame; no back-to-back txNewData.
- Pointer wrap: grant=3 last, req=4'b1001 → next grant=0, then 3.
- enable=0 asserted mid-frame → frame completes, state LOCKED, txLock=1, no ack. enable=1 → SYNC → next pending req served.
- Core model stuck at busy=0 after txNewData → after 16 cycles error=1, active=0, returns to SYNC, no further ack until busy handshake resumes; error stays 1.
- RESET_InLow pulsed low during data bits → all outputs at reset values the same cycle; after release, SYNC handshake precedes any new grant.
